// File: rtl/tag_verify128.sv
// tag_verify128: assembles a 128-bit tag from a serial keystream (LSB first)
// and compares it in constant time against a latched expected tag.
// Latency: start at edge E0, 128 accepted bits, one COMPARE cycle, then done.
// Backpressure: ks_ready is high only in COLLECT; ks_valid=0 stalls the
// collection with no state change. done is a level held until ack or start.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, exp_tag    begin a verification; exp_tag sampled on accepted start
//   ks_valid, ks_bit  serial tag bits, first accepted bit is tag[0]
//   ks_ready          high while bits are being collected
//   ack               consumer releases the result (DONE -> IDLE)
//   busy              high in COLLECT or COMPARE
//   done, match, tag  registered result; match is 0 whenever done is 0
module tag_verify128 #(
  // Only 128 is supported: the bit counter and index widths assume it.
  parameter int TAG_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TAG_BITS-1:0] exp_tag,
  input  logic                ks_valid,
  input  logic                ks_bit,
  output logic                ks_ready,
  input  logic                ack,
  output logic                busy,
  output logic                done,
  output logic                match,
  output logic [TAG_BITS-1:0] tag
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state;
  logic [7:0]          cnt;
  logic [TAG_BITS-1:0] tag_q;
  logic [TAG_BITS-1:0] exp_q;
  logic                done_q;
  logic                match_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      tag_q   <= '0;
      exp_q   <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_q <= exp_tag;
            tag_q <= '0;
            cnt   <= 8'd0;
            state <= COLLECT;
          end
        end

        COLLECT: begin
          if (ks_valid) begin
            tag_q[cnt[6:0]] <= ks_bit;
            // cnt reaches 128 after the last bit; it is cleared only by the
            // next accepted start, so it never wraps within a verification.
            cnt <= cnt + 8'd1;
            if (cnt == 8'd127) begin
              state <= COMPARE;
            end
          end
        end

        COMPARE: begin
          // Full-width XOR reduce every time: no data-dependent early exit.
          match_q <= ~|(tag_q ^ exp_q);
          done_q  <= 1'b1;
          state   <= DONE;
        end

        DONE: begin
          // A new start doubles as an implicit acknowledge.
          if (start) begin
            exp_q   <= exp_tag;
            tag_q   <= '0;
            cnt     <= 8'd0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            state   <= COLLECT;
          end else if (ack) begin
            done_q  <= 1'b0;
            match_q <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ks_ready = (state == COLLECT);
  assign busy     = (state == COLLECT) || (state == COMPARE);
  assign done     = done_q;
  assign match    = match_q;
  assign tag      = tag_q;

endmodule

// File: tb/tb_tag_verify128.sv
// Testbench for tag_verify128: random and directed verifications with a
// queue-based scoreboard; a negedge monitor checks every result as done rises.
module tb_tag_verify128;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] exp_tag;
  logic         ks_valid;
  logic         ks_bit;
  logic         ks_ready;
  logic         ack;
  logic         busy;
  logic         done;
  logic         match;
  logic [127:0] tag;

  always #5 clk = ~clk;

  tag_verify128 #(.TAG_BITS(128)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .exp_tag  (exp_tag),
    .ks_valid (ks_valid),
    .ks_bit   (ks_bit),
    .ks_ready (ks_ready),
    .ack      (ack),
    .busy     (busy),
    .done     (done),
    .match    (match),
    .tag      (tag)
  );

  typedef struct {
    logic [127:0] tag;
    logic         match;
    int           exp_edge;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_n = 0;
  logic mon_en = 1'b0;

  localparam logic [127:0] VEC = 128'h0123456789ABCDEF_FEDCBA9876543210;

  always @(posedge clk) edge_n++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // Monitor: pops an expectation on each rising done; checks hold stability.
  logic         prev_done = 1'b0;
  logic [127:0] held_tag;
  logic         held_match;
  exp_t         mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (done === 1'b1 && prev_done !== 1'b1) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: done=1 at edge %0d with no pending verification", edge_n);
        end else begin
          mon_e = sb_q.pop_front();
          check("result_tag", tag, mon_e.tag);
          check("result_match", {127'b0, match}, {127'b0, mon_e.match});
          check("done_edge", edge_n, mon_e.exp_edge);
        end
        held_tag   = tag;
        held_match = match;
      end else if (done === 1'b1) begin
        check("held_tag", tag, held_tag);
        check("held_match", {127'b0, match}, {127'b0, held_match});
      end else begin
        check("match_low_without_done", {127'b0, match}, 128'd0);
      end
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ks_valid always high; 1: toggles 1,0,1,0; 2: random with noise
  // on start/ack while collecting.
  task automatic run_txn(input logic [127:0] e, input logic [127:0] s,
                         input int mode, input logic with_ack);
    int   i;
    int   k;
    int   last;
    logic v;
    start   = 1'b1;
    exp_tag = e;
    ack     = with_ack;
    tick();
    start   = 1'b0;
    ack     = 1'b0;
    exp_tag = {$urandom, $urandom, $urandom, $urandom};
    check("busy_after_start", {127'b0, busy}, 128'd1);
    check("done_after_start", {127'b0, done}, 128'd0);
    i = 0;
    k = 0;
    while (i < 128) begin
      check("ks_ready_collect", {127'b0, ks_ready}, 128'd1);
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (k % 2 == 0);
      else                v = 1'($urandom_range(0, 1));
      ks_valid = v;
      ks_bit   = v ? s[i] : 1'($urandom_range(0, 1));
      if (mode == 2) begin
        start = ($urandom_range(0, 3) == 0);
        ack   = ($urandom_range(0, 3) == 0);
      end
      tick();
      if (v) i++;
      k++;
    end
    last     = edge_n;
    ks_valid = 1'b0;
    start    = 1'b0;
    ack      = 1'b0;
    sb_q.push_back('{s, (s == e), last + 1});
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wait_done: done still %b after %0d cycles", done, n);
    end
  endtask

  task automatic finish_ack(input logic [127:0] s);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("done_after_ack", {127'b0, done}, 128'd0);
    check("busy_after_ack", {127'b0, busy}, 128'd0);
    check("tag_retained_idle", tag, s);
    tick();
    check("tag_still_retained", tag, s);
  endtask

  initial begin
    logic [127:0] e;
    logic [127:0] s;
    int           kind;
    int           idx;

    rst      = 1'b1;
    start    = 1'b0;
    ack      = 1'b0;
    ks_valid = 1'b1;
    ks_bit   = 1'b1;
    exp_tag  = '1;
    repeat (3) tick();
    check("rst_busy", {127'b0, busy}, 128'd0);
    check("rst_done", {127'b0, done}, 128'd0);
    check("rst_match", {127'b0, match}, 128'd0);
    check("rst_tag", tag, 128'd0);
    check("rst_ks_ready", {127'b0, ks_ready}, 128'd0);

    // Reset beats start in the same cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_over_start", {127'b0, busy}, 128'd0);
    mon_en = 1'b1;

    // ks_valid high in IDLE must not touch anything.
    rst = 1'b0;
    repeat (3) tick();
    check("idle_ks_valid_tag", tag, 128'd0);
    check("idle_ks_valid_busy", {127'b0, busy}, 128'd0);
    check("idle_ks_ready", {127'b0, ks_ready}, 128'd0);

    // Straight match, then hold done without ack for 10 cycles.
    run_txn(VEC, VEC, 0, 1'b0);
    wait_done();
    repeat (10) tick();
    finish_ack(VEC);

    // Single-bit mismatch on bit 127.
    s = VEC;
    s[127] = ~s[127];
    run_txn(VEC, s, 0, 1'b0);
    wait_done();
    check("mismatch_bit127", {127'b0, tag[127]}, {127'b0, ~VEC[127]});
    finish_ack(s);

    // Alternating valid stalls.
    run_txn(VEC, VEC, 1, 1'b0);
    wait_done();
    finish_ack(VEC);

    // Reset after 60 bits discards the partial tag.
    start   = 1'b1;
    exp_tag = VEC;
    tick();
    start = 1'b0;
    for (int b = 0; b < 60; b++) begin
      ks_valid = 1'b1;
      ks_bit   = VEC[b];
      tick();
    end
    ks_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {127'b0, busy}, 128'd0);
    check("midrst_tag", tag, 128'd0);
    check("midrst_done", {127'b0, done}, 128'd0);
    check("midrst_ks_ready", {127'b0, ks_ready}, 128'd0);

    // Start accepted right after reset release; then hold done and restart
    // with start and ack together.
    run_txn(VEC, VEC, 0, 1'b0);
    wait_done();
    repeat (10) tick();
    e = {$urandom, $urandom, $urandom, $urandom};
    run_txn(e, e, 0, 1'b1);
    wait_done();
    finish_ack(e);

    // Randomized verifications.
    for (int t = 0; t < 8; t++) begin
      e    = {$urandom, $urandom, $urandom, $urandom};
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        s = e;
      end else if (kind == 1) begin
        s   = e;
        idx = $urandom_range(0, 127);
        s[idx] = ~s[idx];
      end else begin
        s = {$urandom, $urandom, $urandom, $urandom};
      end
      run_txn(e, s, 2, 1'b0);
      wait_done();
      repeat ($urandom_range(0, 3)) tick();
      finish_ack(s);
    end

    repeat (3) tick();
    check("scoreboard_empty", sb_q.size(), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
